// File: rtl/router_pkg.sv
// Shared types for the row-router sequencer.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE, INIT, COORD, WSTALL, TCMP, DWAIT, DOUT, DONE
  } rseq_state_t;

endpackage

// File: rtl/rseq_coord_gen.sv
// Index/coordinate counters for the sequencer: y fastest, then x, stepped by stride.
module rseq_coord_gen
  import router_pkg::*;
#(
  parameter int unsigned ROW_COUNT    = 4,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned STRIDE_WIDTH = 4,
  localparam int unsigned ROW_W       = $clog2(ROW_COUNT)
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic                    clr,
  input  logic                    load,
  input  logic                    batch_init,
  input  logic                    advance,
  input  logic [ADDR_WIDTH-1:0]   w,
  input  logic [ADDR_WIDTH-1:0]   h,
  input  logic [STRIDE_WIDTH-1:0] stride,
  output logic [ROW_W-1:0]        row_id,
  output logic [ADDR_WIDTH-1:0]   x,
  output logic [ADDR_WIDTH-1:0]   y,
  output logic                    row_last,
  output logic                    coord_last
);

  localparam logic [ADDR_WIDTH-1:0] A_ONE   = 1;
  localparam logic [ROW_W-1:0]      ROW_ONE = 1;
  localparam logic [ROW_W-1:0]      ROW_MAX = ROW_W'(ROW_COUNT - 1);

  logic [ADDR_WIDTH-1:0] ix, iy, w_m1, h_m1, step;

  assign w_m1       = w - A_ONE;
  assign h_m1       = h - A_ONE;
  assign step       = ADDR_WIDTH'(stride);
  assign row_last   = (row_id == ROW_MAX);
  assign coord_last = (ix == w_m1) && (iy == h_m1);

  // Wrap decisions use the index counters; x/y are running sums that may truncate.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      ix     <= '0;
      iy     <= '0;
      x      <= '0;
      y      <= '0;
      row_id <= '0;
    end else if (clr || load) begin
      ix     <= '0;
      iy     <= '0;
      x      <= '0;
      y      <= '0;
      row_id <= '0;
    end else begin
      if (batch_init)
        row_id <= '0;
      else if (advance)
        row_id <= row_id + ROW_ONE;
      if (advance) begin
        if (iy == h_m1) begin
          iy <= '0;
          y  <= '0;
          ix <= ix + A_ONE;
          x  <= x + step;
        end else begin
          iy <= iy + A_ONE;
          y  <= y + step;
        end
      end
    end
  end

endmodule

// File: rtl/router_sequencer.sv
// Batch sequencer for the row-router array: issue coordinates, tile compare, data-out handshake.
// Optional stall-cycle counter enabled by defining ROUTER_SEQ_STALL_CNT_EN.
module router_sequencer
  import router_pkg::*;
#(
  parameter int unsigned ROW_COUNT    = 4,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned STRIDE_WIDTH = 4,
  localparam int unsigned ROW_W       = $clog2(ROW_COUNT)
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic                    i_clr,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_o_w,
  input  logic [ADDR_WIDTH-1:0]   i_o_h,
  input  logic [STRIDE_WIDTH-1:0] i_stride,
  output logic                    o_coord_valid,
  input  logic                    i_route_ready,
  output logic [ROW_W-1:0]        o_row_id,
  output logic [ADDR_WIDTH-1:0]   o_o_x,
  output logic [ADDR_WIDTH-1:0]   o_o_y,
  output logic                    o_tile_read_en,
  output logic                    o_ac_en,
  input  logic                    i_addr_empty,
  output logic                    o_data_valid,
  input  logic                    i_data_ready,
  output logic                    o_pop_en,
  input  logic                    i_data_empty,
  output logic                    o_batch_clr,
  output logic                    o_busy,
  output logic                    o_done
`ifdef ROUTER_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]             o_stall_cycles
`endif
);

  rseq_state_t               state;
  logic [ADDR_WIDTH-1:0]     w_q, h_q;
  logic [STRIDE_WIDTH-1:0]   stride_q;
  logic                      last_q, tile_en, start_ok, transfer, row_last, coord_last;

  assign start_ok       = ((state == IDLE) || (state == DONE)) && i_start;
  assign transfer       = o_coord_valid && i_route_ready;
  assign o_tile_read_en = tile_en;
  assign o_ac_en        = tile_en;

  rseq_coord_gen #(
    .ROW_COUNT   (ROW_COUNT),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STRIDE_WIDTH(STRIDE_WIDTH)
  ) u_coord (
    .i_clk     (i_clk),
    .i_nrst    (i_nrst),
    .clr       (i_clr),
    .load      (start_ok),
    .batch_init(state == INIT),
    .advance   (transfer),
    .w         (w_q),
    .h         (h_q),
    .stride    (stride_q),
    .row_id    (o_row_id),
    .x         (o_o_x),
    .y         (o_o_y),
    .row_last  (row_last),
    .coord_last(coord_last)
  );

  // Outputs are set together with the state they belong to, so they stay registered.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= IDLE;
      {w_q, h_q, stride_q, last_q} <= '0;
      {o_coord_valid, tile_en, o_data_valid, o_pop_en, o_batch_clr, o_busy, o_done} <= '0;
    end else if (i_clr) begin
      state <= IDLE;
      {w_q, h_q, stride_q, last_q} <= '0;
      {o_coord_valid, tile_en, o_data_valid, o_pop_en, o_batch_clr, o_busy, o_done} <= '0;
    end else begin
      o_batch_clr <= 1'b0;
      case (state)
        IDLE, DONE: if (i_start) begin
          state    <= INIT;
          w_q      <= i_o_w;
          h_q      <= i_o_h;
          stride_q <= i_stride;
          last_q   <= 1'b0;
          o_busy   <= 1'b1;
          o_done   <= 1'b0;
        end
        INIT: if ((w_q == '0) || (h_q == '0)) begin
          state  <= DONE;
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end else begin
          state         <= COORD;
          o_coord_valid <= 1'b1;
        end
        COORD: if (transfer && (row_last || coord_last)) begin
          state         <= WSTALL;
          o_coord_valid <= 1'b0;
          last_q        <= coord_last;
        end
        WSTALL: begin
          state   <= TCMP;
          tile_en <= 1'b1;
        end
        TCMP: if (i_addr_empty) begin
          state        <= DWAIT;
          tile_en      <= 1'b0;
          o_data_valid <= 1'b1;
        end
        DWAIT: if (i_data_ready) begin
          state        <= DOUT;
          o_data_valid <= 1'b0;
          o_pop_en     <= 1'b1;
        end
        DOUT: if (i_data_empty) begin
          o_pop_en    <= 1'b0;
          o_batch_clr <= 1'b1;
          if (last_q) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
            state <= INIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROUTER_SEQ_STALL_CNT_EN
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)
      o_stall_cycles <= '0;
    else if (i_clr || start_ok)
      o_stall_cycles <= '0;
    else if ((((state == COORD) && !i_route_ready) || ((state == DWAIT) && !i_data_ready))
             && (o_stall_cycles != '1))
      o_stall_cycles <= o_stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_router_sequencer.sv
// Self-checking bench for router_sequencer: vector table, random runs, hand-written corner cases.
module tb_router_sequencer;

  localparam int ROW = 4;
  localparam int AW  = 8;
  localparam int SW  = 4;

  logic          clk = 1'b0, nrst = 1'b0, clr = 1'b0, start = 1'b0;
  logic [AW-1:0] ow = '0, oh = '0;
  logic [SW-1:0] stride = '0;
  logic          route_ready = 1'b0, addr_empty = 1'b0, data_ready = 1'b0, data_empty = 1'b0;
  logic          coord_valid, tile_read_en, ac_en, data_valid, pop_en, batch_clr, busy, done;
  logic [1:0]    row_id;
  logic [AW-1:0] ox, oy;
`ifdef ROUTER_SEQ_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  router_sequencer #(.ROW_COUNT(ROW), .ADDR_WIDTH(AW), .STRIDE_WIDTH(SW)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_clr(clr), .i_start(start),
    .i_o_w(ow), .i_o_h(oh), .i_stride(stride),
    .o_coord_valid(coord_valid), .i_route_ready(route_ready), .o_row_id(row_id),
    .o_o_x(ox), .o_o_y(oy), .o_tile_read_en(tile_read_en), .o_ac_en(ac_en),
    .i_addr_empty(addr_empty), .o_data_valid(data_valid), .i_data_ready(data_ready),
    .o_pop_en(pop_en), .i_data_empty(data_empty), .o_batch_clr(batch_clr),
    .o_busy(busy), .o_done(done)
`ifdef ROUTER_SEQ_STALL_CNT_EN
    , .o_stall_cycles(stall_cycles)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint all_outputs();
    return longint'({coord_valid, row_id, ox, oy, tile_read_en, ac_en,
                     data_valid, pop_en, batch_clr, busy, done});
  endfunction

  // mode 0: all handshakes ready, 1: random, 2: hold 2nd coord 3 cycles, 3: delay data_ready 5 cycles
  task automatic run_case(input int w, input int h, input int s, input int mode,
                          output int batches, output int coords, output int lx,
                          output int ly, output int lrow, output int held,
                          output int busy_cycles);
    int q[$];
    int total, in_batch, hold_left, dr_left, first_valid, exp_sz, k;
    bit fin;
    k = 0;
    for (int ix = 0; ix < w; ix++)
      for (int iy = 0; iy < h; iy++) begin
        q.push_back(((k % ROW) << 16) | (((ix * s) & 255) << 8) | ((iy * s) & 255));
        k++;
      end
    total = w * h;
    batches = 0; coords = 0; lx = -1; ly = -1; lrow = -1; held = 0; busy_cycles = 0;
    in_batch = 0; hold_left = 3; dr_left = 5; first_valid = -1; fin = 1'b0;

    @(negedge clk);
    ow = AW'(w); oh = AW'(h); stride = SW'(s); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      route_ready = 1'b1; addr_empty = 1'b1; data_ready = 1'b1; data_empty = 1'b1;
      case (mode)
        1: begin
          route_ready = ($urandom_range(0, 3) != 0);
          addr_empty  = ($urandom_range(0, 2) == 0);
          data_ready  = ($urandom_range(0, 1) == 0);
          data_empty  = ($urandom_range(0, 2) == 0);
        end
        2: if (coord_valid && coords == 1 && hold_left > 0) begin
          route_ready = 1'b0;
          hold_left--;
        end
        3: if (data_valid && dr_left > 0) begin
          data_ready = 1'b0;
          dr_left--;
        end
        default: ;
      endcase
      if (coord_valid && first_valid < 0) first_valid = cyc;
      if (busy) busy_cycles++;
      check("busy_vs_done", longint'(busy), longint'(!done));
      if (coord_valid && coords == 1) held++;
      if (coord_valid && route_ready) begin
        if (q.size() == 0) check("extra_coord", 1, 0);
        else check("coord_row_x_y", longint'({row_id, ox, oy}), longint'(q.pop_front()));
        lx = int'(ox); ly = int'(oy); lrow = int'(row_id);
        coords++; in_batch++;
      end
      if (batch_clr) begin
        exp_sz = total - batches * ROW;
        if (exp_sz > ROW) exp_sz = ROW;
        check("batch_size", in_batch, exp_sz);
        batches++; in_batch = 0;
      end
      if (done) fin = 1'b1;
    end
    check("done_reached", longint'(fin), 1);
    check("coords_total", coords, total);
    if (total > 0) check("first_valid_latency", first_valid, 1);
  endtask

  typedef struct {
    int w, h, s, mode;
    int batches, lx, ly, lrow;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int b, c, lx, ly, lr, held, bc, w, h, s;

    tbl[0] = '{2,   2, 1,  0, 1,   1,   1,  3};
    tbl[1] = '{3,   3, 2,  0, 3,   4,   4,  0};
    tbl[2] = '{0,   5, 1,  0, 0,  -1,  -1, -1};
    tbl[3] = '{5,   0, 1,  1, 0,  -1,  -1, -1};
    tbl[4] = '{1,   1, 3,  1, 1,   0,   0,  0};
    tbl[5] = '{4,   3, 5,  1, 3,  15,  10,  3};
    tbl[6] = '{200, 2, 15, 1, 100, 169, 15, 3};
    tbl[7] = '{1,   7, 2,  0, 2,   0,  12,  2};

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    nrst = 1'b1;
    @(negedge clk);
    check("idle_outputs", all_outputs(), 0);

    foreach (tbl[i]) begin
      run_case(tbl[i].w, tbl[i].h, tbl[i].s, tbl[i].mode, b, c, lx, ly, lr, held, bc);
      check("tbl_batches", b, tbl[i].batches);
      check("tbl_last_x", lx, tbl[i].lx);
      check("tbl_last_y", ly, tbl[i].ly);
      check("tbl_last_row", lr, tbl[i].lrow);
      if (tbl[i].batches == 0) check("zero_busy_cycles", bc, 1);
    end

    for (int r = 0; r < 6; r++) begin
      w = $urandom_range(0, 9);
      h = $urandom_range(0, 9);
      s = $urandom_range(0, 15);
      run_case(w, h, s, 1, b, c, lx, ly, lr, held, bc);
      check("rand_batches", b, (w * h + ROW - 1) / ROW);
    end

    run_case(2, 2, 1, 2, b, c, lx, ly, lr, held, bc);
    check("hold_cycles", held, 4);
    check("hold_batches", b, 1);

    @(negedge clk);
    ow = 8'd2; oh = 8'd2; stride = 4'd1; start = 1'b1;
    route_ready = 1'b1; addr_empty = 1'b0; data_ready = 1'b1; data_empty = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !tile_read_en; i++) @(negedge clk);
    check("reach_tcmp", longint'(tile_read_en), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_outputs", all_outputs(), 0);
    @(negedge clk);
    check("clr_stays_idle", all_outputs(), 0);
    run_case(3, 3, 2, 0, b, c, lx, ly, lr, held, bc);
    check("rerun_batches", b, 3);
    check("rerun_last_x", lx, 4);
    check("rerun_last_y", ly, 4);

`ifdef ROUTER_SEQ_STALL_CNT_EN
    run_case(2, 2, 1, 3, b, c, lx, ly, lr, held, bc);
    check("stall_cycles", longint'(stall_cycles), 5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
